// File: rtl/board_port_arbiter.sv
// board_port_arbiter: shares the single board-memory port between the game
// FSM (writes), the victory checker (locked read scans) and the display reader.
// Fixed priority: promoted display > write (unlocked only) > checker > display.
// Read data returns one cycle after the grant through a registered rdata.
// Optional macro DISPLAY_STARVE_GUARD_EN enables the display starvation guard;
// without it the display is strictly lowest priority.
module board_port_arbiter #(
  parameter int ROW_BITS     = 3,
  parameter int COL_BITS     = 3,
  parameter int DATA_BITS    = 2,
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req,
  input  logic [ROW_BITS-1:0]  wr_row,
  input  logic [COL_BITS-1:0]  wr_col,
  input  logic [DATA_BITS-1:0] wr_data,
  output logic                 wr_gnt,
  input  logic                 chk_req,
  input  logic                 chk_lock,
  input  logic [ROW_BITS-1:0]  chk_row,
  input  logic [COL_BITS-1:0]  chk_col,
  output logic                 chk_gnt,
  output logic                 chk_rvalid,
  input  logic                 disp_req,
  input  logic [ROW_BITS-1:0]  disp_row,
  input  logic [COL_BITS-1:0]  disp_col,
  output logic                 disp_gnt,
  output logic                 disp_rvalid,
  output logic [DATA_BITS-1:0] rdata,
  output logic [ROW_BITS-1:0]  mem_row,
  output logic [COL_BITS-1:0]  mem_col,
  output logic                 mem_write,
  output logic [DATA_BITS-1:0] mem_wdata,
  input  logic [DATA_BITS-1:0] mem_rdata
);

  typedef enum logic {
    FREE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t state_reg, state_next;

  logic                 promote;
  logic [DATA_BITS-1:0] rdata_reg;
  logic                 chk_rvalid_reg;
  logic                 disp_rvalid_reg;

  // Lock state register; reset always returns to FREE, even with chk_lock high
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= FREE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: the sampled chk_lock decides the lock for the following cycle
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FREE:    if (chk_lock)  state_next = LOCKED;
      LOCKED:  if (!chk_lock) state_next = FREE;
      default: state_next = FREE;
    endcase
  end

`ifdef DISPLAY_STARVE_GUARD_EN
  logic [STARVE_BITS-1:0] starve_cnt_reg, starve_cnt_next;

  // Count consecutive denied display cycles, saturating at the limit
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!disp_req || disp_gnt) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != STARVE_BITS'(STARVE_LIMIT)) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

  assign promote = (starve_cnt_reg == STARVE_BITS'(STARVE_LIMIT));
`else
  // Guard removed: keep the sizing parameters referenced but inert
  logic [STARVE_BITS-1:0] unused_starve_limit;
  assign unused_starve_limit = STARVE_BITS'(STARVE_LIMIT);
  assign promote = 1'b0;
`endif

  // Grant outputs: one-hot fixed priority, all forced low while in reset
  always_comb begin
    wr_gnt   = 1'b0;
    chk_gnt  = 1'b0;
    disp_gnt = 1'b0;
    if (!rst) begin
      if (disp_req && promote) begin
        disp_gnt = 1'b1;
      end else if (wr_req && (state_reg == FREE)) begin
        wr_gnt = 1'b1;
      end else if (chk_req) begin
        chk_gnt = 1'b1;
      end else if (disp_req) begin
        disp_gnt = 1'b1;
      end
    end
  end

  // Address/data mux follows the grant; idle cycles present the display address
  always_comb begin
    mem_row   = disp_row;
    mem_col   = disp_col;
    mem_wdata = '0;
    if (wr_gnt) begin
      mem_row   = wr_row;
      mem_col   = wr_col;
      mem_wdata = wr_data;
    end else if (chk_gnt) begin
      mem_row = chk_row;
      mem_col = chk_col;
    end
  end

  assign mem_write = wr_gnt;

  // Registered read return: capture on read grants, flag the owner for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_reg       <= '0;
      chk_rvalid_reg  <= 1'b0;
      disp_rvalid_reg <= 1'b0;
    end else begin
      chk_rvalid_reg  <= chk_gnt;
      disp_rvalid_reg <= disp_gnt;
      if (chk_gnt || disp_gnt) begin
        rdata_reg <= mem_rdata;
      end
    end
  end

  assign rdata       = rdata_reg;
  assign chk_rvalid  = chk_rvalid_reg;
  assign disp_rvalid = disp_rvalid_reg;

endmodule
